// File: rtl/onewire_master_pkg.sv
// ---------------------------------------------------------------------------
// onewire_master_pkg
//
// Shared definitions for the 1-Wire bus master:
//   - command op encodings carried on cmd_op
//   - FSM state encodings (plain localparams so older tools can consume them)
//   - slot timing constants, all expressed in microseconds
//   - slot_timing(): maps a latched op/bit pair to its slot parameters
// ---------------------------------------------------------------------------
package onewire_master_pkg;

  // Width of the microsecond counter; 10 bits covers the 960 us reset slot.
  localparam int US_W = 10;

  // Command op encodings.
  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  // FSM state encodings.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_NOP  = 2'b01;
  localparam logic [1:0] ST_LOW  = 2'b10;
  localparam logic [1:0] ST_REL  = 2'b11;

  // Slot timing in microseconds, measured from the first cycle of the slot.
  localparam logic [US_W-1:0] T_RST_LOW    = 10'd480;
  localparam logic [US_W-1:0] T_RST_SAMPLE = 10'd550;
  localparam logic [US_W-1:0] T_RST_TOTAL  = 10'd960;
  localparam logic [US_W-1:0] T_W1_LOW     = 10'd6;
  localparam logic [US_W-1:0] T_W0_LOW     = 10'd60;
  localparam logic [US_W-1:0] T_RD_SAMPLE  = 10'd15;
  localparam logic [US_W-1:0] T_SLOT       = 10'd70;

  // Everything the FSM needs to know about the slot in progress.
  typedef struct packed {
    logic [US_W-1:0] low;        // us the line is held low
    logic [US_W-1:0] sample;     // us at which the line is sampled
    logic [US_W-1:0] total;      // us at which the slot completes
    logic            has_sample; // reset and read slots sample, writes do not
  } slot_timing_t;

  // Slot parameters for a latched op. Read slots start with the same short
  // low pulse as a write-1 so the device sees a standard read initiation.
  function automatic slot_timing_t slot_timing(input logic [1:0] op,
                                               input logic       bit_val);
    slot_timing_t t;
    t.low        = T_W1_LOW;
    t.sample     = '0;
    t.total      = T_SLOT;
    t.has_sample = 1'b0;
    case (op)
      OP_RESET: begin
        t.low        = T_RST_LOW;
        t.sample     = T_RST_SAMPLE;
        t.total      = T_RST_TOTAL;
        t.has_sample = 1'b1;
      end
      OP_WRITE: begin
        t.low = bit_val ? T_W1_LOW : T_W0_LOW;
      end
      OP_READ: begin
        t.sample     = T_RD_SAMPLE;
        t.has_sample = 1'b1;
      end
      default: ;
    endcase
    return t;
  endfunction

endpackage : onewire_master_pkg

// File: rtl/onewire_us_tick.sv
// ---------------------------------------------------------------------------
// onewire_us_tick
//
// Microsecond prescaler. Counts 0..CLKS_PER_US-1 and raises tick_o for the
// single cycle in which the count sits at its terminal value, so the
// consumer advances exactly once per microsecond. clr_i restarts the count
// so a slot's time base is aligned to the cycle its command was accepted.
//
// Ports:
//   clk     system clock
//   reset   synchronous, active-high reset
//   clr_i   synchronous clear of the prescaler count
//   tick_o  one-cycle pulse every CLKS_PER_US cycles
// ---------------------------------------------------------------------------
module onewire_us_tick #(
  parameter int CLKS_PER_US = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = $clog2(CLKS_PER_US);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_US - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // NOTE: cnt_d gets a default before any branch so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold the value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign tick_o = (cnt_q == LAST);

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : onewire_us_tick

// File: rtl/onewire_master.sv
// ---------------------------------------------------------------------------
// onewire_master
//
// Open-drain 1-Wire bus master. Executes one time slot per accepted
// command: reset/presence, write bit or read bit. The line is only ever
// pulled low (pad_t = 0) or released (pad_t = 1); the external pull-up
// provides the high level. The line is observed through a two-flop
// synchronizer and all slot timing derives from a 1 us prescaler tick
// feeding a 10-bit microsecond counter.
//
// Timing, for a command accepted at edge N:
//   pad_t falls at N+1, rises at N+1+t_low*CLKS_PER_US
//   sample taken at N+1+t_sample*CLKS_PER_US
//   done (and cmd_ready) high from edge N+1+t_total*CLKS_PER_US
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   cmd_valid  command request
//   cmd_op     00 reset/presence, 01 write bit, 10 read bit, 11 no-op
//   cmd_bit    bit value for writes
//   cmd_ready  high when idle; accept = cmd_valid & cmd_ready
//   done       one-cycle pulse at slot completion
//   rx_bit     last sampled read bit
//   presence   1 = device answered the last reset slot
//   pad_t      pad tri-state control: 0 = drive, 1 = release
//   pad_i      pad data input, tied to 0
//   pad_in     asynchronous line level from the pad
// ---------------------------------------------------------------------------
module onewire_master
  import onewire_master_pkg::*;
#(
  parameter int CLKS_PER_US = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  input  logic       cmd_bit,
  output logic       cmd_ready,
  output logic       done,
  output logic       rx_bit,
  output logic       presence,
  output logic       pad_t,
  output logic       pad_i,
  input  logic       pad_in
);

  // Line synchronizer.
  logic sync1_q;
  logic pad_sync_q;

  // FSM and slot context.
  logic [1:0]      state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic            bit_q, bit_d;
  logic [US_W-1:0] us_q, us_d;
  logic            us_new_q, us_new_d;

  // Registered outputs.
  logic cmd_ready_q, cmd_ready_d;
  logic done_q, done_d;
  logic rx_bit_q, rx_bit_d;
  logic presence_q, presence_d;
  logic pad_t_q, pad_t_d;

  logic         accept;
  logic         tick;
  slot_timing_t tim;

  assign accept = cmd_valid && cmd_ready_q;
  assign tim    = slot_timing(op_q, bit_q);

  onewire_us_tick #(
    .CLKS_PER_US (CLKS_PER_US)
  ) u_us_tick (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (accept),
    .tick_o (tick)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    bit_d       = bit_q;
    us_d        = us_q;
    us_new_d    = tick;
    cmd_ready_d = cmd_ready_q;
    done_d      = 1'b0;
    rx_bit_d    = rx_bit_q;
    presence_d  = presence_q;
    pad_t_d     = 1'b1;

    // us_new_q marks the first cycle at each new microsecond value, so a
    // comparison against us_q fires once even though us_q holds for
    // CLKS_PER_US cycles.
    if (tick && (state_q != ST_IDLE)) begin
      us_d = us_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          us_d        = '0;
          us_new_d    = 1'b0;
          cmd_ready_d = 1'b0;
          if (cmd_op == OP_NOP) begin
            state_d = ST_NOP;
          end else begin
            state_d = ST_LOW;
            op_d    = cmd_op;
            bit_d   = cmd_bit;
          end
        end
      end

      ST_NOP: begin
        done_d      = 1'b1;
        cmd_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end

      ST_LOW: begin
        // pad_t is registered from the current state, so it falls one
        // cycle after accept and rises on the edge that leaves LOW.
        if (us_q == tim.low) begin
          state_d = ST_REL;
        end else begin
          pad_t_d = 1'b0;
        end
      end

      ST_REL: begin
        if (us_new_q && tim.has_sample && (us_q == tim.sample)) begin
          if (op_q == OP_RESET) begin
            presence_d = ~pad_sync_q;
          end else begin
            rx_bit_d = pad_sync_q;
          end
        end
        if (us_q == tim.total) begin
          done_d      = 1'b1;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      pad_sync_q  <= 1'b1;
      state_q     <= ST_IDLE;
      op_q        <= OP_NOP;
      bit_q       <= 1'b0;
      us_q        <= '0;
      us_new_q    <= 1'b0;
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
      rx_bit_q    <= 1'b0;
      presence_q  <= 1'b0;
      pad_t_q     <= 1'b1;
    end else begin
      sync1_q     <= pad_in;
      pad_sync_q  <= sync1_q;
      state_q     <= state_d;
      op_q        <= op_d;
      bit_q       <= bit_d;
      us_q        <= us_d;
      us_new_q    <= us_new_d;
      cmd_ready_q <= cmd_ready_d;
      done_q      <= done_d;
      rx_bit_q    <= rx_bit_d;
      presence_q  <= presence_d;
      pad_t_q     <= pad_t_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign done      = done_q;
  assign rx_bit    = rx_bit_q;
  assign presence  = presence_q;
  assign pad_t     = pad_t_q;
  // The line is never driven high: the pad only ever drives a 0.
  assign pad_i     = 1'b0;

endmodule : onewire_master

// File: tb/tb_onewire_master.sv
// ---------------------------------------------------------------------------
// tb_onewire_master
//
// Self-checking bench for onewire_master with CLKS_PER_US = 4. A
// behavioural model tracks each accepted command by its accept edge and
// derives every output from the slot timing table in relative cycles. The
// attached device is a per-command "pull low" window in cycles after the
// accept edge; the line is the wired-AND of master and device.
// ---------------------------------------------------------------------------
module tb_onewire_master;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_bit;
  logic       cmd_ready, done, rx_bit, presence, pad_t, pad_i;
  logic       pad_in;
  logic       dev_low;

  int dev_ds, dev_de;
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  assign pad_in = pad_t & ~dev_low;

  onewire_master #(.CLKS_PER_US(C)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_bit   (cmd_bit),
    .cmd_ready (cmd_ready),
    .done      (done),
    .rx_bit    (rx_bit),
    .presence  (presence),
    .pad_t     (pad_t),
    .pad_i     (pad_i),
    .pad_in    (pad_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slot table in microseconds.
  function automatic int low_us(input logic [1:0] op, input logic b);
    case (op)
      2'b00:   return 480;
      2'b01:   return b ? 6 : 60;
      2'b10:   return 6;
      default: return 0;
    endcase
  endfunction

  function automatic int samp_us(input logic [1:0] op);
    case (op)
      2'b00:   return 550;
      2'b10:   return 15;
      default: return 0;
    endcase
  endfunction

  function automatic int tot_us(input logic [1:0] op);
    return (op == 2'b00) ? 960 : 70;
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  bit         m_on = 0;
  logic       m_ready, m_done, m_pad_t, m_rx, m_pres;
  bit         s_act = 0;
  int         s_acc, s_ds, s_de, lowc, samc, totc;
  logic [1:0] s_op;
  logic       h0 = 1'b1, h1 = 1'b1, h2 = 1'b1; // line level after the last 3 edges

  initial begin : model
    int rel;
    dev_low = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        m_on = 1; m_ready = 1; m_done = 0; m_pad_t = 1; m_rx = 0; m_pres = 0;
        s_act = 0;
      end else if (m_on) begin
        m_done = 0;
        if (s_act) begin
          rel = cyc - s_acc;
          if (s_op == 2'b11) begin
            if (rel == 1) begin m_done = 1; m_ready = 1; s_act = 0; end
          end else begin
            m_pad_t = !(rel >= 1 && rel <= lowc);
            // The master sees the line as it was 2 cycles before the sample edge.
            if (samc > 0 && rel == 1 + samc) begin
              if (s_op == 2'b00) m_pres = ~h2;
              else               m_rx   = h2;
            end
            if (rel == 1 + totc) begin m_done = 1; m_ready = 1; s_act = 0; end
          end
        end else if (cmd_valid && m_ready) begin
          s_act = 1; s_acc = cyc; s_op = cmd_op;
          s_ds = dev_ds; s_de = dev_de; m_ready = 0;
          lowc = low_us(cmd_op, cmd_bit) * C;
          samc = samp_us(cmd_op) * C;
          totc = tot_us(cmd_op) * C;
        end
      end
      @(negedge clk);
      if (s_act && s_op != 2'b11) begin
        rel = cyc - s_acc;
        dev_low = (rel >= s_ds) && (rel < s_de);
      end else begin
        dev_low = 1'b0;
      end
      h2 = h1; h1 = h0; h0 = m_pad_t & ~dev_low;
      if (m_on)
        check("outputs{ready,done,rx,pres,pad_t,pad_i}",
              32'({cmd_ready, done, rx_bit, presence, pad_t, pad_i}),
              32'({m_ready, m_done, m_rx, m_pres, m_pad_t, 1'b0}));
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic [1:0] op, input logic b, input int ds, input int de);
    cmd_valid = 1'b1; cmd_op = op; cmd_bit = b; dev_ds = ds; dev_de = de;
  endtask

  // Called at the negedge where a command was issued. mode: 0 quiet,
  // 1 hold a read request during the slot, 2 random requests during the slot.
  task automatic wait_slot(input int mode, output int done_rel,
                           output int low_w, output int first_low);
    done_rel = -1; low_w = 0; first_low = -1;
    @(negedge clk);
    cmd_valid = (mode == 1);
    if (mode == 1) cmd_op = 2'b10;
    for (int n = 1; n <= 4500; n++) begin
      @(negedge clk);
      if (pad_t === 1'b0) begin
        low_w++;
        if (first_low < 0) first_low = n;
      end
      if (done === 1'b1) begin done_rel = n; break; end
      if (mode == 2) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_bit   = 1'($urandom_range(0, 1));
      end
    end
    cmd_valid = 1'b0;
    check("slot_done_seen", 32'(done_rel > 0), 32'd1);
  endtask

  initial begin : stim
    int dr, lw, fl, quiet;
    int r, ds, de, samc_r;
    logic [1:0] op;
    logic b;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b11; cmd_bit = 1'b0;
    dev_ds = 0; dev_de = 0;
    repeat (3) @(negedge clk);
    check("reset_state", 32'({cmd_ready, done, rx_bit, presence, pad_t, pad_i}), 32'h22);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Reset slot, device low 500..620 us.
    issue(2'b00, 1'b0, 1 + 500 * C, 1 + 620 * C);
    wait_slot(0, dr, lw, fl);
    check("rst_first_low", fl, 1);
    check("rst_low_width", lw, 1920);
    check("rst_done_cycle", dr, 3841);
    check("rst_presence", 32'(presence), 1);

    // Write 0 then write 1, second accepted in the done cycle.
    issue(2'b01, 1'b0, 0, 0);
    wait_slot(0, dr, lw, fl);
    check("w0_low_width", lw, 240);
    check("w0_done_cycle", dr, 281);
    issue(2'b01, 1'b1, 0, 0);
    wait_slot(0, dr, lw, fl);
    check("w1_low_width", lw, 24);
    check("w1_done_cycle", dr, 281);

    // Read with device low until 30 us, then read with no device.
    issue(2'b10, 1'b0, 0, 1 + 30 * C);
    wait_slot(0, dr, lw, fl);
    check("rd0_rx_bit", 32'(rx_bit), 0);
    check("rd0_done_cycle", dr, 281);
    issue(2'b10, 1'b0, 0, 0);
    wait_slot(0, dr, lw, fl);
    check("rd1_rx_bit", 32'(rx_bit), 1);
    check("rd1_done_cycle", dr, 281);

    // Busy request held during a write slot is ignored; then a no-op.
    issue(2'b01, 1'b1, 0, 0);
    wait_slot(1, dr, lw, fl);
    check("busy_low_width", lw, 24);
    check("busy_done_cycle", dr, 281);
    quiet = 0;
    repeat (5) begin
      @(negedge clk);
      if (pad_t === 1'b1 && done === 1'b0) quiet++;
    end
    check("busy_ignored_quiet", quiet, 5);
    issue(2'b11, 1'b0, 0, 0);
    wait_slot(0, dr, lw, fl);
    check("nop_done_cycle", dr, 1);
    check("nop_low_width", lw, 0);

    // A presence of 1 first, then reset 200 us into a reset slot.
    issue(2'b00, 1'b0, 1 + 500 * C, 1 + 620 * C);
    wait_slot(0, dr, lw, fl);
    check("pres_before_rst", 32'(presence), 1);
    issue(2'b00, 1'b0, 0, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (200 * C) @(negedge clk);
    check("mid_slot_pad_low", 32'(pad_t), 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_state", 32'({cmd_ready, done, presence, pad_t}), 32'h9);

    // Reset slot with no device.
    repeat (2) @(negedge clk);
    issue(2'b00, 1'b0, 0, 0);
    wait_slot(0, dr, lw, fl);
    check("nodev_presence", 32'(presence), 0);
    check("nodev_done_cycle", dr, 3841);

    // Randomized commands, device windows and busy-time requests.
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 15);
      op = (r < 2) ? 2'b00 : (r < 4) ? 2'b11 : (r < 10) ? 2'b01 : 2'b10;
      b = 1'($urandom_range(0, 1));
      samc_r = samp_us(op) * C;
      if (samc_r > 0 && $urandom_range(0, 1) == 1) begin
        // Put the device edge right around the synchronized sample point.
        ds = samc_r - 2 + $urandom_range(0, 2);
        de = ds + $urandom_range(1, 40);
      end else begin
        ds = $urandom_range(0, tot_us(op) * C + 4);
        de = ds + $urandom_range(0, tot_us(op) * C);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(op, b, ds, de);
      wait_slot($urandom_range(0, 1) * 2, dr, lw, fl);
      check("rand_done_cycle", dr, (op == 2'b11) ? 1 : 1 + tot_us(op) * C);
    end

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: got no end of test, want end before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_onewire_master
